// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller that
// drives the write strobes and mux selects of the PC/SP/memory block, plus a
// 16-bit retired-instruction counter.
// Optional feature macro: CTRL_HALT_EN (opcode 0xF parks the machine in HALT
// until reset; when undefined, 0xF decodes as a nop and `halted` is 0).
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] inst,
    input  logic        cmp_true,
    output logic        PCWrite,
    output logic [2:0]  PCSrc,
    output logic        SPWrite,
    output logic [2:0]  SPSrc,
    output logic        InstWrite,
    output logic        MemWrite,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic        RegWrite,
    output logic [2:0]  state,
    output logic [15:0] icount,
    output logic        halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_J    = 4'h1;
    localparam logic [3:0] OP_JR   = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_PUSH = 4'h5;
    localparam logic [3:0] OP_POP  = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]  state_q, state_d;
    logic [15:0] icount_q, icount_d;
    logic [3:0]  op;
    logic        is_alu;
    logic        retire;
    logic        unused_inst_bits;

    assign op               = inst[15:12];
    assign is_alu           = (op >= 4'h8) && (op <= 4'hE);
    assign unused_inst_bits = ^inst[11:0];

    // Next-state sequencing per instruction class
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOP:                     state_d = S_FETCH;
                    OP_J, OP_JR, OP_BEQ:        state_d = S_EXEC;
                    OP_LW, OP_SW, OP_PUSH, OP_POP: state_d = S_MEM;
`ifdef CTRL_HALT_EN
                    OP_HALT:                    state_d = S_HALT;
`else
                    OP_HALT:                    state_d = S_FETCH;
`endif
                    default:                    state_d = S_EXEC;  // ALU 0x8-0xE
                endcase
            end
            S_EXEC:   state_d = is_alu ? S_WB : S_FETCH;
            S_MEM:    state_d = (op == OP_LW || op == OP_POP) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
`ifdef CTRL_HALT_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // One count per retired instruction; entering HALT also retires the 0xF
    always_comb begin
        retire   = ((state_q != S_FETCH) && (state_d == S_FETCH)) ||
                   ((state_q != S_HALT)  && (state_d == S_HALT));
        icount_d = icount_q + {15'd0, retire};
    end

    // State and counter registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            icount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    // Strobe/select decode of state and opcode; strobes are masked during reset
    // so a mid-instruction reset never produces a partial write
    always_comb begin
        PCWrite   = 1'b0;
        PCSrc     = 3'd0;
        SPWrite   = 1'b0;
        SPSrc     = 3'd0;
        InstWrite = 1'b0;
        MemWrite  = 1'b0;
        MemSrc    = 2'd0;
        MemDst    = 3'd0;
        RegWrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                InstWrite = 1'b1;
                PCWrite   = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_J:   begin PCWrite = 1'b1;     PCSrc = 3'd1; end
                    OP_JR:  begin PCWrite = 1'b1;     PCSrc = 3'd2; end
                    OP_BEQ: begin PCWrite = cmp_true; PCSrc = 3'd4; end
                    default: ;
                endcase
            end
            S_MEM: begin
                case (op)
                    OP_LW:   MemSrc = 2'd2;
                    OP_SW:   begin MemSrc = 2'd2; MemWrite = 1'b1; end
                    OP_PUSH: begin
                        MemSrc   = 2'd1;
                        MemWrite = 1'b1;
                        SPWrite  = 1'b1;
                        SPSrc    = 3'd1;
                    end
                    OP_POP:  begin MemSrc = 2'd1; SPWrite = 1'b1; SPSrc = 3'd2; end
                    default: ;
                endcase
            end
            S_WB:    RegWrite = 1'b1;
            default: ;
        endcase
        if (!reset) begin
            PCWrite   = 1'b0;
            SPWrite   = 1'b0;
            InstWrite = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
        end
    end

    assign state  = state_q;
    assign icount = icount_q;
`ifdef CTRL_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control state machine that sits directly upstream of the PC/SP/memory block and drives every write strobe and mux select into it. It fetches an instruction into that block's instruction register, decodes the latched `inst[15:12]` opcode, and sequences EXEC, MEM and WB cycles per instruction class. It also keeps a retired-instruction counter for bring-up and test.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `inst`  in  16  latched instruction (Inst_out of the memory block); opcode is `inst[15:12]`.
- `cmp_true`  in  1  comparator result; branch is taken when it is 1.
- `PCWrite`  out  1  PC register write enable.
- `PCSrc`  out  3  PC source: 0 sequential next PC, 1 ze_imm, 2 RA, 3 Mary, 4 comparator target.
- `SPWrite`  out  1  SP register write enable.
- `SPSrc`  out  3  SP update: 0 hold, 1 decrement, 2 increment.
- `InstWrite`  out  1  instruction register write enable.
- `MemWrite`  out  1  memory write enable.
- `MemSrc`  out  2  memory address: 0 PC, 1 SP, 2 ze_imm, 3 ls_imm.
- `MemDst`  out  3  memory write data: 0 Mary, 1 Shelley, 2 RA.
- `RegWrite`  out  1  register file write enable.
- `state`  out  3  current state encoding, for debug.
- `icount`  out  16  retired-instruction count.
- `halted`  out  1  1 while in HALT (see Configuration).

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- The state, `icount` and halt are registered. All other outputs are combinational decode of `state` and `inst`. Any strobe not listed for a state is 0, and all selects default to 0.
- FETCH:
  - Outputs: `MemSrc`=0, `InstWrite`=1, `PCWrite`=1, `PCSrc`=0.
  - Next state: DECODE.
- DECODE: no strobes. Next state by opcode:
  - 0x0 nop: FETCH.
  - 0x1 j, 0x2 jr, 0x7 beq: EXEC.
  - 0x3 lw, 0x4 sw, 0x5 push, 0x6 pop: MEM.
  - 0x8–0xE ALU: EXEC.
  - 0xF: see Configuration.
- EXEC:
  - j: `PCWrite`=1, `PCSrc`=1.
  - jr: `PCWrite`=1, `PCSrc`=2.
  - beq: `PCSrc`=4, with `PCWrite`=`cmp_true`.
  - Next state: FETCH for j/jr/beq; WB for ALU.
- MEM:
  - lw: `MemSrc`=2, then WB.
  - sw: `MemSrc`=2, `MemWrite`=1, `MemDst`=0, then FETCH.
  - push: `MemSrc`=1, `MemWrite`=1, `MemDst`=0, `SPWrite`=1, `SPSrc`=1, then FETCH.
  - pop: `MemSrc`=1, `SPWrite`=1, `SPSrc`=2, then WB.
- WB: `RegWrite`=1, next state FETCH. Read data comes from the MemVal register, which is valid in the cycle after MEM.
- `icount` increments by 1 on every transition into FETCH from a non-FETCH state, i.e. one count per retired instruction. It is 16-bit and wraps from 0xFFFF to 0x0000.

## Timing
- Reset (`reset`=0 at a clock edge):
  - `state`=FETCH, `icount`=0, `halted`=0.
  - While `reset` is low, all strobes (`PCWrite`, `SPWrite`, `InstWrite`, `MemWrite`, `RegWrite`) are forced to 0 regardless of state.
  - The first fetch strobe appears in the first cycle with `reset`=1.
- Reset asserted mid-instruction aborts it: no partial write occurs in the reset cycle, and the machine restarts at FETCH.
- Cycles per instruction:
  - nop: 2.
  - j, jr, beq, sw, push: 3.
  - ALU, lw, pop: 4.
- `inst` is sampled only in DECODE, EXEC, MEM and WB. Changes on `inst` during FETCH are ignored.
- `cmp_true` is sampled only in the EXEC cycle of beq.

## Configuration
- `CTRL_HALT_EN` defined:
  - Opcode 0xF enters HALT from DECODE and `icount` increments on entry.
  - HALT asserts `halted`=1 and no strobes.
  - HALT is left only by reset.
- `CTRL_HALT_EN` undefined:
  - Opcode 0xF behaves as nop.
  - `halted` is tied to 0 and the HALT state is unreachable.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release -> `state`=0, `icount`=0, all strobes 0 during reset; `InstWrite`=1 and `PCWrite`=1 in the first released cycle.
- Three nops (`inst`=0x0000) -> `state` sequence 0,1,0,1,0,1; `icount`=3.
- beq (`inst`=0x7000): with `cmp_true`=1 -> EXEC shows `PCSrc`=4, `PCWrite`=1; with `cmp_true`=0 -> `PCWrite`=0; both cases take 3 cycles.
- push (0x5000), then pop (0x6000) -> push MEM: `MemWrite`=1, `SPSrc`=1, `MemSrc`=1; pop MEM: `SPSrc`=2, `MemWrite`=0; pop WB: `RegWrite`=1; `icount`=2.
- Preload `icount`=0xFFFF via 65535 nops, then one more nop -> `icount`=0x0000.
- `CTRL_HALT_EN` defined, `inst`=0xF000 -> `halted`=1, strobes stay 0 for 10 cycles, `reset`=0 clears `halted`; with the macro undefined, same stimulus gives a 2-cycle nop.
